// File: rtl/iomem_xbar.sv
// iomem crossbar: decodes equal-sized windows onto NUM_SLAVES peripherals, one
// transaction at a time, with a per-access timeout and a saturating error counter.
module iomem_xbar #(
    parameter int          NUM_SLAVES = 4,
    parameter int          WIN_AW     = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     iomem_valid,
    output logic                     iomem_ready,
    input  logic [3:0]               iomem_wstrb,
    input  logic [31:0]              iomem_addr,
    input  logic [31:0]              iomem_wdata,
    output logic [31:0]              iomem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [3:0]               s_wstrb,
    output logic [WIN_AW-1:0]        s_addr,
    output logic [31:0]              s_wdata,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    output logic                     err_pulse,
    output logic [7:0]               err_cnt
);
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_TERM = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic [CW-1:0]         to_cnt_q;
    logic                  iomem_ready_q, err_pulse_q;
    logic [31:0]           iomem_rdata_q, s_wdata_q;
    logic [NUM_SLAVES-1:0] s_valid_q;
    logic [3:0]            s_wstrb_q;
    logic [WIN_AW-1:0]     s_addr_q;
    logic [7:0]            err_cnt_q;

    logic [31:0] off_d, win_d, wdata_d, sel_rdata_d;
    logic        hit_d, sel_ready_d, to_hit_d;
    logic [7:0]  err_cnt_d;

    always_comb begin
        off_d = iomem_addr - BASE_ADDR;
        win_d = off_d >> WIN_AW;
        hit_d = (iomem_addr >= BASE_ADDR) && (win_d < 32'(NUM_SLAVES));
        for (int b = 0; b < 4; b++)
            wdata_d[8*b +: 8] = iomem_wstrb[b] ? iomem_wdata[8*b +: 8] : 8'h00;
        err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end

    // Only the latched slave's ready/data are ever looked at.
    always_comb begin
        sel_rdata_d = '0;
        sel_ready_d = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_rdata_d = s_rdata[32*i +: 32];
                sel_ready_d = s_ready[i];
            end
        end
        to_hit_d = (TIMEOUT != 0) && (to_cnt_q == TO_TERM);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            to_cnt_q      <= '0;
            iomem_ready_q <= 1'b0;
            iomem_rdata_q <= '0;
            s_valid_q     <= '0;
            s_wstrb_q     <= '0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            err_pulse_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iomem_valid && !iomem_ready_q) begin
                        if (hit_d) begin
                            idx_q     <= win_d[IW-1:0];
                            s_addr_q  <= iomem_addr[WIN_AW-1:0];
                            s_wstrb_q <= iomem_wstrb;
                            s_wdata_q <= wdata_d;
                            s_valid_q <= NUM_SLAVES'(1) << win_d[IW-1:0];
                            to_cnt_q  <= '0;
                            state_q   <= ACCESS;
                        end else begin
                            iomem_rdata_q <= ERR_DATA;
                            iomem_ready_q <= 1'b1;
                            err_pulse_q   <= 1'b1;
                            err_cnt_q     <= err_cnt_d;
                            state_q       <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    // A slave answering on the terminal cycle beats the timeout.
                    if (sel_ready_d) begin
                        s_valid_q     <= '0;
                        iomem_rdata_q <= (s_wstrb_q == 4'h0) ? sel_rdata_d : 32'h0;
                        iomem_ready_q <= 1'b1;
                        state_q       <= RESP;
                    end else if (to_hit_d) begin
                        s_valid_q     <= '0;
                        iomem_rdata_q <= ERR_DATA;
                        iomem_ready_q <= 1'b1;
                        err_pulse_q   <= 1'b1;
                        err_cnt_q     <= err_cnt_d;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    iomem_ready_q <= 1'b0;
                    err_pulse_q   <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign iomem_ready = iomem_ready_q;
    assign iomem_rdata = iomem_rdata_q;
    assign s_valid     = s_valid_q;
    assign s_wstrb     = s_wstrb_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign err_pulse   = err_pulse_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_iomem_xbar.sv
// Self-checking bench for iomem_xbar: randomized accesses against a transaction-level model.
module tb_iomem_xbar;
    localparam int          NS   = 4;
    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int          TO   = 255;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic              clk = 0, resetn = 0;
    logic              iomem_valid = 0, iomem_ready;
    logic [3:0]        iomem_wstrb = 0;
    logic [31:0]       iomem_addr = 0, iomem_wdata = 0, iomem_rdata;
    logic [NS-1:0]     s_valid, s_ready = 0;
    logic [3:0]        s_wstrb;
    logic [AW-1:0]     s_addr;
    logic [31:0]       s_wdata;
    logic [32*NS-1:0]  s_rdata = 0;
    logic              err_pulse;
    logic [7:0]        err_cnt;

    int checks = 0, errors = 0;
    int model_errs = 0;

    iomem_xbar #(.NUM_SLAVES(NS), .WIN_AW(AW), .BASE_ADDR(BASE), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready), .err_pulse(err_pulse),
        .err_cnt(err_cnt));

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt();
        return (model_errs > 255) ? 8'd255 : 8'(model_errs);
    endfunction

    // One full transaction. The slave raises ready once it has seen s_valid
    // for 'waits' cycles; other slaves toggle ready randomly.
    task automatic do_access(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                             input int waits, input bit drop_early);
        bit hit, exp_err, done, got_err, bad_sv;
        int sel, exp_lat, lat, svcnt;
        logic [31:0] exp_rdata, exp_wd, got_rdata, wd_seen;
        logic [NS-1:0] exp_sv;
        logic [AW-1:0] a_seen;
        logic [3:0] ws_seen;
        logic [31:0] slv [NS];
        hit = (addr >= BASE) && (((addr - BASE) >> AW) < NS);
        sel = hit ? int'((addr - BASE) >> AW) : 0;
        exp_sv = hit ? NS'(1 << sel) : '0;
        for (int i = 0; i < NS; i++) begin
            slv[i] = $urandom;
            s_rdata[32*i +: 32] = slv[i];
        end
        exp_wd = 0;
        for (int b = 0; b < 4; b++) if (ws[b]) exp_wd[8*b +: 8] = wd[8*b +: 8];
        exp_err = !hit || (waits >= TO);
        exp_lat = !hit ? 1 : (waits >= TO) ? TO + 1 : waits + 2;
        exp_rdata = exp_err ? ERRD : (ws != 0) ? 32'h0 : slv[sel];
        if (exp_err) model_errs++;

        @(negedge clk);
        iomem_valid = 1; iomem_addr = addr; iomem_wstrb = ws; iomem_wdata = wd;
        s_ready = NS'($urandom) & ~exp_sv;
        done = 0; lat = 0; svcnt = 0; bad_sv = 0; got_err = 0; got_rdata = 0;
        a_seen = 0; ws_seen = 0; wd_seen = 0;
        while (!done && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
            if (drop_early && lat == 1) iomem_valid = 0;
            if (s_valid !== '0) begin
                svcnt++;
                if (svcnt == 1) begin a_seen = s_addr; ws_seen = s_wstrb; wd_seen = s_wdata; end
                if (s_valid !== exp_sv) bad_sv = 1;
            end
            if (iomem_ready === 1'b1) begin
                done = 1; got_rdata = iomem_rdata; got_err = err_pulse;
                s_ready = 0;
            end else begin
                s_ready = NS'($urandom) & ~exp_sv;
                if (hit && svcnt > waits) s_ready = s_ready | exp_sv;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL timeout addr=%h no iomem_ready within 1000 cycles", addr); end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL latency addr=%h got %0d exp %0d", addr, lat, exp_lat); end
        checks++;
        if (got_rdata !== exp_rdata) begin errors++; $display("FAIL rdata addr=%h got %h exp %h", addr, got_rdata, exp_rdata); end
        checks++;
        if (got_err !== exp_err) begin errors++; $display("FAIL err_pulse addr=%h got %0b exp %0b", addr, got_err, exp_err); end
        checks++;
        if (svcnt !== (hit ? exp_lat - 1 : 0) || bad_sv) begin
            errors++; $display("FAIL s_valid addr=%h cycles %0d exp %0d bad_onehot %0b", addr, svcnt, hit ? exp_lat - 1 : 0, bad_sv);
        end
        if (hit) begin
            checks++;
            if (a_seen !== addr[AW-1:0] || ws_seen !== ws || wd_seen !== exp_wd) begin
                errors++; $display("FAIL slave_fields addr=%h got %h/%h/%h exp %h/%h/%h", addr, a_seen, ws_seen, wd_seen, addr[AW-1:0], ws, exp_wd);
            end
        end
        // RESP cycle: valid still held high, nothing may be accepted.
        @(posedge clk); #1;
        checks++;
        if (iomem_ready !== 1'b0 || err_pulse !== 1'b0 || s_valid !== '0) begin
            errors++; $display("FAIL resp_cycle addr=%h ready %0b err %0b s_valid %b exp 0/0/0", addr, iomem_ready, err_pulse, s_valid);
        end
        checks++;
        if (err_cnt !== exp_cnt()) begin errors++; $display("FAIL err_cnt addr=%h got %0d exp %0d", addr, err_cnt, exp_cnt()); end
        iomem_valid = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (iomem_ready !== 0 || iomem_rdata !== 0 || s_valid !== 0 || s_wstrb !== 0 || s_addr !== 0 ||
            s_wdata !== 0 || err_pulse !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL reset_state ready %0b rdata %h s_valid %b err %0b cnt %0d exp all 0",
                               iomem_ready, iomem_rdata, s_valid, err_pulse, err_cnt);
        end
        @(negedge clk); resetn = 1;
        model_errs = 0;
    endtask

    task automatic test_directed();
        do_access(32'h0300_1004, 4'h0, 32'h0, 0, 0);
        do_access(32'h0300_0000, 4'b0101, 32'hAABB_CCDD, 3, 0);
        do_access(32'h0300_4000, 4'h0, 32'h0, 0, 0);
        do_access(32'h0000_0010, 4'hF, 32'h1, 0, 0);
    endtask

    task automatic test_timeout();
        do_access(32'h0300_2010, 4'h0, 32'h0, 1000, 0);
        do_access(32'h0300_2014, 4'h0, 32'h0, TO - 1, 0);
        do_access(32'h0300_3ffc, 4'h3, 32'h5555_AAAA, TO, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int w;
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = BASE + 32'($urandom_range(0, NS * 4096 + 8191));
                default: a = BASE + 32'($urandom_range(0, NS * 4096 - 1));
            endcase
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 3) : $urandom_range(0, 6);
            do_access(a, ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom), $urandom, w, $urandom_range(0, 4) == 0);
        end
    endtask

    task automatic test_back_to_back();
        do_access(32'h0300_0100, 4'h0, 32'h0, 0, 0);
        do_access(32'h0300_3200, 4'hF, 32'h0102_0304, 1, 0);
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 300; n++) do_access(32'h0400_0000 + 32'(n), 4'h0, 32'h0, 0, 0);
        checks++;
        if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_sat got %0d exp 255", err_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iomem_valid = 1; iomem_addr = 32'h0300_1008; iomem_wstrb = 0; s_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_valid !== 4'b0010) begin errors++; $display("FAIL mid_access s_valid got %b exp 0010", s_valid); end
        @(negedge clk); resetn = 0;
        @(posedge clk); #1;
        checks++;
        if (s_valid !== 0 || iomem_ready !== 0 || err_cnt !== 0 || err_pulse !== 0) begin
            errors++; $display("FAIL reset_mid s_valid %b ready %0b cnt %0d err %0b exp 0", s_valid, iomem_ready, err_cnt, err_pulse);
        end
        model_errs = 0;
        iomem_valid = 0;
        @(negedge clk); resetn = 1;
        do_access(32'h0300_1008, 4'h0, 32'h0, 2, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
